// File: rtl/cpu_dbg_pkg.sv
// Shared types and instruction encodings for the CPU step controller.
// Define STEP_CTRL_ILLEGAL_HALT_EN to also halt on all-zero/all-one instruction words.
package cpu_dbg_pkg;

    typedef enum logic [1:0] {
        PAUSED = 2'd0,
        STEP   = 2'd1,
        RUN    = 2'd2,
        HALT   = 2'd3
    } step_state_t;

    localparam logic [31:0] EBREAK_INSTR = 32'h00100073;
    localparam logic [31:0] ILLEGAL_ZERO = 32'h00000000;
    localparam logic [31:0] ILLEGAL_ONES = 32'hFFFFFFFF;

    // Encodings that stop the CPU instead of being executed.
    function automatic logic instr_halts(input logic [31:0] word);
`ifdef STEP_CTRL_ILLEGAL_HALT_EN
        return (word == EBREAK_INSTR) || (word == ILLEGAL_ZERO) || (word == ILLEGAL_ONES);
`else
        return (word == EBREAK_INSTR);
`endif
    endfunction

endpackage

// File: rtl/btn_debouncer.sv
// Synchronizes and debounces an active-low push-button and emits a
// one-cycle event on each accepted released-to-pressed transition.
module btn_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic pressed,
    output logic press_evt
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_reg;
    logic          sync2_reg;
    logic          level_reg;   // debounced button level, 1 = released
    logic [CW-1:0] cnt_reg;
    logic          evt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
            level_reg <= 1'b1;
            cnt_reg   <= '0;
            evt_reg   <= 1'b0;
        end else begin
            sync1_reg <= btn_n;
            sync2_reg <= sync1_reg;
            evt_reg   <= 1'b0;
            // A new level is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
            if (sync2_reg == level_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CW'(DEBOUNCE_CYCLES - 1)) begin
                level_reg <= sync2_reg;
                cnt_reg   <= '0;
                evt_reg   <= ~sync2_reg;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign pressed   = ~level_reg;
    assign press_evt = evt_reg;

endmodule

// File: rtl/cpu_step_controller.sv
// Generates the CPU clock-enable from the board clock: single-step, divided
// free-run, PC breakpoint pause and halt (STEP_CTRL_ILLEGAL_HALT_EN widens halt).
module cpu_step_controller
    import cpu_dbg_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int RUN_DIV         = 5000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        step_btn_n,
    input  logic        run_sw,
    input  logic        bp_en,
    input  logic [31:0] bp_addr,
    input  logic [31:0] pc_addr,
    input  logic [31:0] instr,
    output logic        cpu_ce,
    output logic        halted,
    output logic [1:0]  state,
    output logic [31:0] step_count
);

    localparam int DW = $clog2(RUN_DIV + 1);

    step_state_t   state_reg;
    logic [DW-1:0] div_reg;
    logic [31:0]   count_reg;
    logic          halted_reg;

    logic btn_pressed;
    logic press_evt;
    logic step_req;
    logic is_halt;
    logic is_bp;
    logic terminal;
    logic run_fire;

    btn_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_n    (step_btn_n),
        .pressed  (btn_pressed),
        .press_evt(press_evt)
    );

    assign step_req = press_evt && btn_pressed;
    assign is_halt  = instr_halts(instr);
    assign is_bp    = bp_en && (pc_addr == bp_addr);
    assign terminal = (div_reg == DW'(RUN_DIV - 1));

    // The RUN pulse is decided in the terminal cycle itself so halt/breakpoint
    // always see the PC the pulse would commit, even when RUN_DIV is 1.
    assign run_fire = (state_reg == RUN) && run_sw && terminal && !is_halt && !is_bp;
    assign cpu_ce   = (state_reg == STEP) || run_fire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= PAUSED;
            div_reg    <= '0;
            count_reg  <= '0;
            halted_reg <= 1'b0;
        end else begin
            case (state_reg)
                PAUSED: begin
                    if (run_sw) begin
                        state_reg <= RUN;
                        div_reg   <= '0;
                    end else if (step_req) begin
                        if (is_halt) begin
                            state_reg  <= HALT;
                            halted_reg <= 1'b1;
                        end else begin
                            state_reg <= STEP;
                        end
                    end
                end
                STEP: state_reg <= PAUSED;
                RUN: begin
                    if (!run_sw) begin
                        state_reg <= PAUSED;
                        div_reg   <= '0;
                    end else if (terminal) begin
                        div_reg <= '0;
                        if (is_halt) begin
                            state_reg  <= HALT;
                            halted_reg <= 1'b1;
                        end else if (is_bp) begin
                            state_reg <= PAUSED;
                        end
                    end else begin
                        div_reg <= div_reg + 1'b1;
                    end
                end
                HALT: halted_reg <= 1'b1;
                default: state_reg <= PAUSED;
            endcase

            if (cpu_ce && (count_reg != 32'hFFFFFFFF)) begin
                count_reg <= count_reg + 32'd1;
            end
        end
    end

    assign halted     = halted_reg;
    assign state      = state_reg;
    assign step_count = count_reg;

endmodule
